// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: bit-serial WIDTH-bit subtractor, LSB first, with a
// start/busy/done handshake. Define SIGNED_OVF_EN to add the overflow output.

// One-bit half subtractor: difference and borrow of i_a - i_b.
module half_subtractor (
    input  logic i_a,
    input  logic i_b,
    output logic o_d,
    output logic o_borrow
);
    assign o_d      = i_a ^ i_b;
    assign o_borrow = ~i_a & i_b;
endmodule

module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SIGNED_OVF_EN
    ,
    output logic             overflow
`endif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-2:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;

    logic             w_d1;
    logic             w_b1;
    logic             w_d;
    logic             w_b2;
    logic             w_borrow_nxt;
    logic [WIDTH-1:0] w_res_nxt;

    // Full subtract cell: operand bits first, then the running borrow.
    half_subtractor u_hs1 (
        .i_a      (r_a_sh[0]),
        .i_b      (r_b_sh[0]),
        .o_d      (w_d1),
        .o_borrow (w_b1)
    );

    half_subtractor u_hs2 (
        .i_a      (w_d1),
        .i_b      (r_borrow),
        .o_d      (w_d),
        .o_borrow (w_b2)
    );

    assign w_borrow_nxt = w_b1 | w_b2;
    // Result fills from the top; after WIDTH bits the LSB sits at bit 0.
    assign w_res_nxt    = {w_d, r_res};

    // Sequencer: load on start, one bit per RUN cycle, single-cycle DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_res      <= '0;
            r_cnt      <= '0;
            r_borrow   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SIGNED_OVF_EN
            overflow   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_state  <= S_RUN;
                        busy     <= 1'b1;
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_cnt    <= '0;
                        r_borrow <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_res    <= w_res_nxt[WIDTH-1:1];
                    r_borrow <= w_borrow_nxt;
                    if (r_cnt == LAST) begin
                        r_state    <= S_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        diff       <= w_res_nxt;
                        borrow_out <= w_borrow_nxt;
`ifdef SIGNED_OVF_EN
                        // On the last bit the shift regs hold the operand MSBs.
                        overflow   <= (r_a_sh[0] != r_b_sh[0]) &&
                                      (w_d != r_a_sh[0]);
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end
endmodule
